ram_param: RTL and testbench

Parametrised single-port bus-slave RAM: the configurable successor to the fixed 12×8 RAM, with generic data width, address width and depth. Bus-side access uses a `req`/`ready` handshake, and reads return through a registered `rvalid`/`data_out` response. Out-of-range accesses are flagged on `err`. An optional post-reset sweep clears the array to a known value. It sits behind the bus slave interface as local memory for a node.

---
 rtl/ram_param.sv | 132 +++++++++++++
 tb/tb_ram_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param.sv
// Parametrised single-port bus-slave RAM with req/ready handshake and registered read response.
// Optional post-reset clear sweep is enabled by defining RAM_PARAM_INIT_CLEAR_EN.
module ram_param #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 12,
  parameter int                DEPTH      = 4096,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] data_out,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W) || $bits(INIT_VALUE) != DATA_W) begin : g_bad_params
    $error("ram_param: DEPTH must lie in 2..2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Compare one bit wider so DEPTH == 2**ADDR_W still fits.
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign idx      = address[IDX_W-1:0];
  assign accept   = req & ready;

`ifdef RAM_PARAM_INIT_CLEAR_EN

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DEPTH - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep_cnt;
  logic [IDX_W-1:0] sweep_cnt_next;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
    end
  end

  // The counter parks on the last word so it never wraps, even for power-of-two depths.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    mem_we         = 1'b0;
    mem_waddr      = idx;
    mem_wdata      = data_in;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_cnt;
        mem_wdata = INIT_VALUE;
        if (sweep_cnt == LAST_WORD) begin
          state_next = IDLE;
        end else begin
          sweep_cnt_next = sweep_cnt + 1'b1;
        end
      end
      IDLE: begin
        mem_we = accept & wren & in_range;
      end
    endcase
  end

  assign ready = (state == IDLE);

`else

  logic ready_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign ready     = ready_q;
  assign mem_we    = accept & wren & in_range;
  assign mem_waddr = idx;
  assign mem_wdata = data_in;

`endif

  // Array storage has no reset so it maps onto RAM primitives.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rvalid   <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      rvalid <= accept & ~wren;
      err    <= accept & ~in_range;
      if (accept && !wren) begin
        data_out <= in_range ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_param.sv
// Directed self-checking bench for ram_param (DEPTH=20, INIT_VALUE=8'hA5).
// Covers both builds; the sweep sections apply when RAM_PARAM_INIT_CLEAR_EN is defined.
module tb_ram_param;

  localparam int               DATA_W     = 8;
  localparam int               ADDR_W     = 5;
  localparam int               DEPTH      = 20;
  localparam logic [DATA_W-1:0] INIT_VALUE = 8'hA5;

  logic              clock = 1'b0;
  logic              rstn  = 1'b0;
  logic              req   = 1'b0;
  logic              wren  = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] data_out;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic              known [DEPTH];
  logic [DATA_W-1:0] last_data  = '0;
  logic              last_known = 1'b1;

  ram_param #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_VALUE(INIT_VALUE)
  ) dut (
    .clock   (clock),
    .rstn    (rstn),
    .req     (req),
    .wren    (wren),
    .address (address),
    .data_in (data_in),
    .ready   (ready),
    .rvalid  (rvalid),
    .data_out(data_out),
    .err     (err)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
    req     = r;
    wren    = w;
    address = a;
    data_in = d;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    apply_stimulus(1'b1, 1'b1, a, d);
    next_edge();
    check_output($sformatf("wr_rvalid_a%0d", a), rvalid, 1'b0);
    check_output($sformatf("wr_err_a%0d", a), err, (a >= DEPTH));
    if (a < DEPTH) begin
      model[a] = d;
      known[a] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    apply_stimulus(1'b1, 1'b0, a, '0);
    next_edge();
    check_output($sformatf("rd_rvalid_a%0d", a), rvalid, 1'b1);
    check_output($sformatf("rd_err_a%0d", a), err, (a >= DEPTH));
    if (a >= DEPTH) begin
      check_output($sformatf("rd_data_a%0d", a), data_out, '0);
      last_data  = '0;
      last_known = 1'b1;
    end else if (known[a]) begin
      check_output($sformatf("rd_data_a%0d", a), data_out, model[a]);
      last_data  = model[a];
      last_known = 1'b1;
    end else begin
      last_known = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, '0, '0);
    next_edge();
    check_output("idle_rvalid", rvalid, 1'b0);
    check_output("idle_err", err, 1'b0);
    if (last_known) begin
      check_output("idle_data_hold", data_out, last_data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ready"}, ready, 1'b0);
    check_output({tag, "_rvalid"}, rvalid, 1'b0);
    check_output({tag, "_err"}, err, 1'b0);
    check_output({tag, "_data"}, data_out, '0);
  endtask

  task automatic run_sweep(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      next_edge();
      check_output($sformatf("%s_ready_e%0d", tag, k), ready, (k == DEPTH));
      check_output($sformatf("%s_rvalid_e%0d", tag, k), rvalid, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = INIT_VALUE;
      known[i] = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end

    apply_stimulus(1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");

`ifdef RAM_PARAM_INIT_CLEAR_EN
    // A write held during the sweep must be ignored.
    apply_stimulus(1'b1, 1'b1, 5'd5, 8'h77);
    @(negedge clock);
    rstn = 1'b1;
    run_sweep("sweep");
    for (int i = 0; i < DEPTH; i++) begin
      do_read(5'(i));
    end
    idle_cycle();
`else
    @(negedge clock);
    rstn = 1'b1;
    #1;
    check_output("ready_before_edge", ready, 1'b0);
    next_edge();
    check_output("ready_after_edge", ready, 1'b1);
`endif

    // Back-to-back writes, then streaming reads in address order.
    for (int i = 0; i < 4; i++) begin
      do_write(5'(i), 8'(8'h10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i));
    end
    idle_cycle();

    do_write(5'd7, 8'h3C);
    do_read(5'd7);
    idle_cycle();

    // Boundaries and out-of-range accesses.
    do_read(5'd19);
    do_read(5'd20);
    do_read(5'd25);
    do_write(5'd25, 8'hFF);
    do_write(5'd20, 8'hFF);
    idle_cycle();

    for (int i = 0; i < DEPTH; i++) begin
      do_read(5'(i));
    end
    idle_cycle();

`ifdef RAM_PARAM_INIT_CLEAR_EN
    // Reset with a read response pending, then reset again mid-sweep.
    do_read(5'd7);
    rstn = 1'b0;
    #1;
    check_reset_outputs("pending_reset");
    apply_stimulus(1'b1, 1'b1, 5'd7, 8'h77);
    @(negedge clock);
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      next_edge();
      check_output($sformatf("partial_ready_e%0d", k), ready, 1'b0);
    end
    rstn = 1'b0;
    @(negedge clock);
    rstn = 1'b1;
    run_sweep("resweep");
    for (int i = 0; i < DEPTH; i++) begin
      do_read(5'(i));
    end
    idle_cycle();
`else
    // Contents survive reset when no sweep is built in.
    do_write(5'd3, 8'h11);
    idle_cycle();
    rstn = 1'b0;
    #1;
    check_output("pulse_ready_low", ready, 1'b0);
    @(negedge clock);
    rstn = 1'b1;
    next_edge();
    check_output("pulse_ready_high", ready, 1'b1);
    do_read(5'd3);
    do_read(5'd7);
    idle_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
